// File: rtl/pc_gen_pkg.sv
// Shared types for the fetch-stage PC generator: FSM states, redirect sources
// and the pending-redirect record.
package pc_gen_pkg;

    localparam int XLEN_DEFAULT = 32;

    typedef enum logic [1:0] {
        PC_BOOT    = 2'd0,
        PC_RUN     = 2'd1,
        PC_HALTED  = 2'd2
    } pc_state_e;

    typedef enum logic [1:0] {
        REDIR_NONE = 2'd0,
        REDIR_EX   = 2'd1,
        REDIR_TRAP = 2'd2
    } redir_src_e;

    typedef struct packed {
        redir_src_e                src;
        logic [XLEN_DEFAULT-1:0]   target;
    } pending_redir_t;

endpackage

// File: rtl/pc_redirect_latch.sv
// Holds a redirect that arrived while fetch could not advance. A latched trap
// is never displaced by a later EX correction; the entry clears once applied.
module pc_redirect_latch
    import pc_gen_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            set_trap_i,
    input  logic            set_ex_i,
    input  logic [XLEN-1:0] target_i,
    input  logic            clear_i,
    output logic            valid_o,
    output logic [1:0]      src_o,
    output logic [XLEN-1:0] target_o
);

    redir_src_e      src_q, src_d;
    logic [XLEN-1:0] target_q, target_d;

    always_comb begin
        src_d    = src_q;
        target_d = target_q;
        if (set_trap_i) begin
            src_d    = REDIR_TRAP;
            target_d = target_i;
        end else if (set_ex_i && (src_q != REDIR_TRAP)) begin
            src_d    = REDIR_EX;
            target_d = target_i;
        end else if (clear_i) begin
            src_d    = REDIR_NONE;
            target_d = '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            src_q    <= REDIR_NONE;
            target_q <= '0;
        end else begin
            src_q    <= src_d;
            target_q <= target_d;
        end
    end

    assign valid_o  = (src_q != REDIR_NONE);
    assign src_o    = src_q;
    assign target_o = target_q;

endmodule

// File: rtl/pc_gen_unit.sv
// Fetch-stage PC generator: prioritised next-PC selection (trap, EX correction,
// latched redirect, predicted target, sequential) under a BOOT/RUN/HALTED FSM.
module pc_gen_unit
    import pc_gen_pkg::*;
#(
    parameter int              XLEN         = XLEN_DEFAULT,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0,
    parameter int              INSTR_BYTES  = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            pc_write,
    input  logic            imem_ready,
    input  logic            ex_redirect_valid,
    input  logic [XLEN-1:0] ex_redirect_target,
    input  logic            trap_valid,
    input  logic [XLEN-1:0] trap_vector,
    input  logic            pred_taken,
    input  logic [XLEN-1:0] pred_target,
    input  logic            halt_req,
    input  logic            resume_req,
    output logic [XLEN-1:0] pc_o,
    output logic            pc_valid_o,
    output logic [XLEN-1:0] pc_plus_o,
    output logic            redirect_pending_o,
    output logic [1:0]      state_o
);

    localparam int              ALIGN      = $clog2(INSTR_BYTES);
    localparam logic [XLEN-1:0] ALIGN_MASK = {XLEN{1'b1}} << ALIGN;

    pc_state_e       state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic            adv;
    logic            pend_valid;
    logic [1:0]      pend_src;
    logic [XLEN-1:0] pend_target;
    logic            set_trap, set_ex, clear_pend;
    logic [XLEN-1:0] latch_target;

    assign adv       = imem_ready && (state_q == PC_RUN);
    assign pc_plus_o = pc_q + XLEN'(INSTR_BYTES);

    // Redirects that cannot be applied now are parked; anything applied on an
    // advancing cycle consumes whatever was parked.
    assign set_trap     = trap_valid && !adv;
    assign set_ex       = ex_redirect_valid && !trap_valid && !adv;
    assign clear_pend   = adv && (trap_valid || ex_redirect_valid || pend_valid);
    assign latch_target = (trap_valid ? trap_vector : ex_redirect_target) & ALIGN_MASK;

    pc_redirect_latch #(
        .XLEN (XLEN)
    ) u_latch (
        .clk        (clk),
        .reset      (reset),
        .set_trap_i (set_trap),
        .set_ex_i   (set_ex),
        .target_i   (latch_target),
        .clear_i    (clear_pend),
        .valid_o    (pend_valid),
        .src_o      (pend_src),
        .target_o   (pend_target)
    );

    always_comb begin
        pc_d = pc_q;
        if (adv) begin
            if (trap_valid) begin
                pc_d = trap_vector & ALIGN_MASK;
            end else if (ex_redirect_valid) begin
                pc_d = ex_redirect_target & ALIGN_MASK;
            end else if (pend_valid) begin
                pc_d = pend_target;
            end else if (pc_write) begin
                pc_d = pred_taken ? (pred_target & ALIGN_MASK) : pc_plus_o;
            end
        end
    end

    // A halt coinciding with a new redirect is deferred so the redirect lands first.
    always_comb begin
        state_d = state_q;
        case (state_q)
            PC_BOOT:   state_d = PC_RUN;
            PC_RUN:    if (halt_req && !trap_valid && !ex_redirect_valid) state_d = PC_HALTED;
            PC_HALTED: if (resume_req) state_d = PC_RUN;
            default:   state_d = PC_BOOT;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= PC_BOOT;
            pc_q    <= RESET_VECTOR;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    assign pc_o               = pc_q;
    assign pc_valid_o         = (state_q == PC_RUN);
    assign redirect_pending_o = pend_valid;
    assign state_o            = state_q;

endmodule
